// File: rtl/ddc_cfg_defs.sv
// Shared definitions for the DDC configuration sequencers: host address codes and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package ddc_cfg_defs;

  // Host register map (cfg_addr)
  localparam logic [1:0] ADDR_GAIN   = 2'd0;  // gain shadow write
  localparam logic [1:0] ADDR_PASS   = 2'd1;  // pass (bypass) shadow write, bit0
  localparam logic [1:0] ADDR_CLR    = 2'd2;  // clear overflow statistics
  localparam logic [1:0] ADDR_COMMIT = 2'd3;  // start load/sync sequence

  // Configuration sequence FSM
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_FRAME = 3'd2,
    ST_SYNC       = 3'd3,
    ST_SETTLE     = 3'd4
  } cfg_state_t;

endpackage

// File: rtl/ovf_event_counter.sv
// Saturating event counter with sticky flag; clear has priority over increment.
// Latency: count/sticky update one cycle after i_inc_en / i_clr are sampled.
// Backpressure: none; holds at all-ones once saturated.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   i_clr        synchronous clear of count and sticky (wins over i_inc_en)
//   i_inc_en     count one event this cycle
//   o_count      saturating event count
//   o_sticky     set by any counted event, cleared only by i_clr / reset
module ovf_event_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_sticky
);

  logic [WIDTH-1:0] r_count;
  logic             r_sticky;
  logic             w_at_max;

  assign w_at_max = (r_count == {WIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= '0;
      r_sticky <= 1'b0;
    end else if (i_clr) begin
      r_count  <= '0;
      r_sticky <= 1'b0;
    end else if (i_inc_en) begin
      if (!w_at_max) begin
        r_count <= r_count + 1'b1;
      end
      r_sticky <= 1'b1;
    end
  end

  assign o_count  = r_count;
  assign o_sticky = r_sticky;

endmodule

// File: rtl/nco_gain_cfg_ctrl.sv
// NCO gain/bypass configuration sequencer: shadow regs, gain load, frame-aligned sync, overflow stats.
// Latency: commit at T -> gain strobe T+1; frame_start at F (in WAIT_FRAME) -> config_sync F+1.
// Backpressure: shadow/commit writes while busy are dropped and flagged by a one-cycle cfg_err.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   cfg_wr/addr/wdata     host write port (0 gain, 1 pass, 2 clear stats, 3 commit)
//   frame_start           frame-boundary strobe from the decimation chain
//   overflow_in           saturation indication from the NCO gain datapath
//   cfg_busy, cfg_err     sequence in progress / rejected-write pulse
//   ncogain_indicator     one-cycle gain load strobe, ncogain_param holds the loaded word
//   config_sync           one-cycle activation strobe, nco_pass_flag switches with it
//   ovf_count, ovf_sticky qualified overflow statistics
module nco_gain_cfg_ctrl #(
  parameter int COEBITWIDTH   = 16,
  parameter int CNTBITWIDTH   = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_wr,
  input  logic [1:0]             cfg_addr,
  input  logic [COEBITWIDTH-1:0] cfg_wdata,
  input  logic                   frame_start,
  input  logic                   overflow_in,
  output logic                   cfg_busy,
  output logic                   cfg_err,
  output logic                   ncogain_indicator,
  output logic [COEBITWIDTH-1:0] ncogain_param,
  output logic                   config_sync,
  output logic                   nco_pass_flag,
  output logic [CNTBITWIDTH-1:0] ovf_count,
  output logic                   ovf_sticky
);

  import ddc_cfg_defs::*;

  // Settle counter runs 0 .. SETTLE_CYCLES-1 while in SETTLE.
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  cfg_state_t             r_state;
  cfg_state_t             w_next;
  logic [COEBITWIDTH-1:0] r_gain_shadow;
  logic                   r_pass_shadow;
  logic [SW-1:0]          r_settle_cnt;

  logic                   r_cfg_busy;
  logic                   r_cfg_err;
  logic                   r_gain_ind;
  logic [COEBITWIDTH-1:0] r_gain_param;
  logic                   r_cfg_sync;
  logic                   r_pass_flag;

  logic w_idle;
  logic w_wr_gain;
  logic w_wr_pass;
  logic w_wr_clr;
  logic w_wr_commit;
  logic w_wr_reject;
  logic w_ovf_qual;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_wr_gain   = cfg_wr && (cfg_addr == ADDR_GAIN);
  assign w_wr_pass   = cfg_wr && (cfg_addr == ADDR_PASS);
  assign w_wr_clr    = cfg_wr && (cfg_addr == ADDR_CLR);
  assign w_wr_commit = cfg_wr && (cfg_addr == ADDR_COMMIT);
  // Everything except a stats clear is refused outside IDLE.
  assign w_wr_reject = cfg_wr && !w_wr_clr && !w_idle;

  // Overflows are not counted while bypassed (datapath not in use) nor during
  // the sync/settle window where the datapath is transitioning to new settings.
  assign w_ovf_qual = overflow_in && !r_pass_flag &&
                      (r_state != ST_SYNC) && (r_state != ST_SETTLE);

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:       if (w_wr_commit) w_next = ST_LOAD;
      ST_LOAD:       w_next = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (frame_start) w_next = ST_SYNC;
      ST_SYNC:       w_next = ST_SETTLE;
      ST_SETTLE:     if (r_settle_cnt == SETTLE_LAST) w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  // State register and settle counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_SETTLE && r_settle_cnt != SETTLE_LAST) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end else begin
        r_settle_cnt <= '0;
      end
    end
  end

  // Shadow registers only accept writes in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gain_shadow <= '0;
      r_pass_shadow <= 1'b0;
    end else if (w_idle) begin
      if (w_wr_gain) r_gain_shadow <= cfg_wdata;
      if (w_wr_pass) r_pass_shadow <= cfg_wdata[0];
    end
  end

  // Outputs are decoded from the next state so they line up with the state
  // they belong to while still coming straight out of flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfg_busy   <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_gain_ind   <= 1'b0;
      r_gain_param <= '0;
      r_cfg_sync   <= 1'b0;
      r_pass_flag  <= 1'b0;
    end else begin
      r_cfg_busy <= (w_next != ST_IDLE);
      r_cfg_err  <= w_wr_reject;
      r_gain_ind <= (w_next == ST_LOAD);
      r_cfg_sync <= (w_next == ST_SYNC);
      if (w_next == ST_LOAD) r_gain_param <= r_gain_shadow;
      if (w_next == ST_SYNC) r_pass_flag  <= r_pass_shadow;
    end
  end

  ovf_event_counter #(
    .WIDTH (CNTBITWIDTH)
  ) u_ovf_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_wr_clr),
    .i_inc_en (w_ovf_qual),
    .o_count  (ovf_count),
    .o_sticky (ovf_sticky)
  );

  assign cfg_busy          = r_cfg_busy;
  assign cfg_err           = r_cfg_err;
  assign ncogain_indicator = r_gain_ind;
  assign ncogain_param     = r_gain_param;
  assign config_sync       = r_cfg_sync;
  assign nco_pass_flag     = r_pass_flag;

endmodule

// File: tb/tb_nco_gain_cfg_ctrl.sv
// Directed bench for nco_gain_cfg_ctrl: a 16-bit counter instance and a 4-bit counter
// instance share all stimulus; expected values are hand-derived cycle by cycle.
module tb_nco_gain_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [15:0] cfg_wdata = 16'h0;
  logic        frame_start = 1'b0;
  logic        overflow_in = 1'b0;

  logic        cfg_busy, cfg_err, ncogain_indicator, config_sync, nco_pass_flag, ovf_sticky;
  logic [15:0] ncogain_param, ovf_count;
  logic        cfg_busy_b, cfg_err_b, ncogain_indicator_b, config_sync_b, nco_pass_flag_b, ovf_sticky_b;
  logic [15:0] ncogain_param_b;
  logic [3:0]  ovf_count_b;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nco_gain_cfg_ctrl #(.COEBITWIDTH(16), .CNTBITWIDTH(16), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .frame_start(frame_start), .overflow_in(overflow_in),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err), .ncogain_indicator(ncogain_indicator),
    .ncogain_param(ncogain_param), .config_sync(config_sync), .nco_pass_flag(nco_pass_flag),
    .ovf_count(ovf_count), .ovf_sticky(ovf_sticky)
  );

  nco_gain_cfg_ctrl #(.COEBITWIDTH(16), .CNTBITWIDTH(4), .SETTLE_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .frame_start(frame_start), .overflow_in(overflow_in),
    .cfg_busy(cfg_busy_b), .cfg_err(cfg_err_b), .ncogain_indicator(ncogain_indicator_b),
    .ncogain_param(ncogain_param_b), .config_sync(config_sync_b), .nco_pass_flag(nco_pass_flag_b),
    .ovf_count(ovf_count_b), .ovf_sticky(ovf_sticky_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle host write; returns in the cycle after the write.
  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cfg_wr    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_wr    = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_busy",  32'(cfg_busy), 0);
    check("rst_err",   32'(cfg_err), 0);
    check("rst_ind",   32'(ncogain_indicator), 0);
    check("rst_param", 32'(ncogain_param), 0);
    check("rst_sync",  32'(config_sync), 0);
    check("rst_pass",  32'(nco_pass_flag), 0);
    check("rst_cnt",   32'(ovf_count), 0);
    check("rst_stky",  32'(ovf_sticky), 0);
    rst = 1'b1;
    tick();

    // ---------------- basic sequence, gain 3, pass 0 ----------------
    wr(2'd0, 16'h0003);
    wr(2'd1, 16'h0000);
    wr(2'd3, 16'h0000);                       // now T+1
    check("t1_ind",   32'(ncogain_indicator), 1);
    check("t1_param", 32'(ncogain_param), 32'h3);
    check("t1_busy",  32'(cfg_busy), 1);
    tick();                                   // T+2
    check("t2_ind",   32'(ncogain_indicator), 0);
    tick(); tick(); tick();                   // T+5
    frame_start = 1'b1;
    tick();                                   // T+6
    frame_start = 1'b0;
    check("t6_sync",  32'(config_sync), 1);
    check("t6_pass",  32'(nco_pass_flag), 0);
    tick();                                   // T+7
    check("t7_sync",  32'(config_sync), 0);
    tick(); tick(); tick();                   // T+10
    check("t10_busy", 32'(cfg_busy), 1);
    tick();                                   // T+11
    check("t11_busy", 32'(cfg_busy), 0);

    // ---------------- pass=1, frame_start in LOAD ignored ----------------
    wr(2'd1, 16'h0001);
    wr(2'd3, 16'h0000);                       // T+1 (LOAD)
    frame_start = 1'b1;
    tick();                                   // T+2
    frame_start = 1'b0;
    check("p2_sync",  32'(config_sync), 0);
    check("p2_busy",  32'(cfg_busy), 1);
    tick();                                   // T+3
    check("p3_pass",  32'(nco_pass_flag), 0);
    frame_start = 1'b1;
    tick();                                   // T+4
    frame_start = 1'b0;
    check("p4_sync",  32'(config_sync), 1);
    check("p4_pass",  32'(nco_pass_flag), 1);
    overflow_in = 1'b1;
    for (int i = 0; i < 8; i++) tick();       // T+12, back in IDLE
    overflow_in = 1'b0;
    check("p_cnt",    32'(ovf_count), 0);
    check("p_stky",   32'(ovf_sticky), 0);
    check("p_busy",   32'(cfg_busy), 0);

    // ---------------- rejected write while busy ----------------
    wr(2'd1, 16'h0000);
    wr(2'd3, 16'h0000);                       // T+1
    tick();                                   // T+2 WAIT_FRAME
    wr(2'd0, 16'h0002);                       // T+3
    check("e3_err",   32'(cfg_err), 1);
    tick();                                   // T+4
    check("e4_err",   32'(cfg_err), 0);
    frame_start = 1'b1;
    tick();                                   // T+5 sync
    frame_start = 1'b0;
    check("e5_pass",  32'(nco_pass_flag), 0);
    for (int i = 0; i < 5; i++) tick();       // T+10 first IDLE cycle
    check("e10_busy", 32'(cfg_busy), 0);
    wr(2'd3, 16'h0000);                       // commit in first IDLE cycle
    check("e_ind",    32'(ncogain_indicator), 1);
    check("e_param",  32'(ncogain_param), 32'h3);
    tick();                                   // T+2
    frame_start = 1'b1;
    tick();                                   // T+3 sync
    frame_start = 1'b0;
    check("e_sync",   32'(config_sync), 1);
    for (int i = 0; i < 5; i++) tick();       // T+8
    check("e_idle",   32'(cfg_busy), 0);

    // ---------------- overflow counting in IDLE ----------------
    wr(2'd2, 16'h0000);
    overflow_in = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    overflow_in = 1'b0;
    check("o_cnt10",  32'(ovf_count), 10);
    check("o_stky",   32'(ovf_sticky), 1);
    check("o_cnt10b", 32'(ovf_count_b), 10);
    wr(2'd3, 16'h0000);                       // T+1
    tick();                                   // T+2
    frame_start = 1'b1;
    tick();                                   // T+3 SYNC
    frame_start = 1'b0;
    overflow_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();       // through SYNC+SETTLE to T+8
    overflow_in = 1'b0;
    check("o_blank",  32'(ovf_count), 10);
    check("o_bidle",  32'(cfg_busy), 0);

    // ---------------- saturation and clear priority ----------------
    wr(2'd2, 16'h0000);
    check("s_clr",    32'(ovf_count), 0);
    check("s_clrs",   32'(ovf_sticky), 0);
    overflow_in = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("s_cnt20",  32'(ovf_count), 20);
    check("s_sat4",   32'(ovf_count_b), 15);
    check("s_stky4",  32'(ovf_sticky_b), 1);
    wr(2'd2, 16'h0000);                       // clear with overflow still high
    overflow_in = 1'b0;
    check("c_cnt",    32'(ovf_count), 0);
    check("c_stky",   32'(ovf_sticky), 0);
    check("c_cntb",   32'(ovf_count_b), 0);
    check("c_stkyb",  32'(ovf_sticky_b), 0);

    // ---------------- reset abort in WAIT_FRAME ----------------
    wr(2'd3, 16'h0000);                       // T+1
    check("r_param1", 32'(ncogain_param), 32'h3);
    tick();                                   // T+2 WAIT_FRAME
    check("r_busy1",  32'(cfg_busy), 1);
    rst = 1'b0;
    #1;
    check("r_busy0",  32'(cfg_busy), 0);
    check("r_param0", 32'(ncogain_param), 0);
    tick();
    rst = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("r_sync",   32'(config_sync), 0);
    tick();
    check("r_sync2",  32'(config_sync), 0);
    check("r_busy2",  32'(cfg_busy), 0);
    check("r_param2", 32'(ncogain_param), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
